// File: rtl/call_panel_pkg.sv
// rtl/call_panel_pkg.sv - shared widths, hall validity mask and door bit indices for call_panel
package call_panel_pkg;

    localparam int NUM_FLOORS = 7;
    localparam int HALL_W     = 14;
    localparam int CAR_W      = 9;

    // Floor 1 has no down call and floor 7 has no up call.
    localparam logic [HALL_W-1:0] HALL_VALID_MASK = 14'h1FFE;

    localparam int DOOR_OPEN_BIT  = 8;
    localparam int DOOR_CLOSE_BIT = 9;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - single-bit tick-sampled debouncer with press pulse
module button_debounce #(
    parameter int DB_COUNT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int             CW   = $clog2(DB_COUNT + 1);
    localparam logic [CW-1:0]  LAST = CW'(DB_COUNT - 1);

    logic [CW-1:0] agree;
    logic          flip;

    // The pulse fires in the cycle whose tick completes the run, alongside the stable update.
    assign flip = tick && (raw != stable) && (agree == LAST);
    assign rise = flip && raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            agree  <= '0;
            stable <= 1'b0;
        end else if (tick) begin
            if (raw == stable) begin
                agree <= '0;
            end else if (agree == LAST) begin
                stable <= ~stable;
                agree  <= '0;
            end else begin
                agree <= agree + 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_panel.sv
// rtl/call_panel.sv - debounces hall/car pushbuttons and latches pending requests for the elevator
module call_panel
    import call_panel_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int DB_COUNT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HALL_W-1:0] rawHall,
    input  logic [CAR_W:1]    rawCar,
    input  logic [HALL_W-1:0] nextFloorButton,
    input  logic [CAR_W:1]    nextInternalButton,
    output logic [HALL_W-1:0] floorButton,
    output logic [CAR_W:1]    internalButton,
    output logic [HALL_W-1:0] hallLamp,
    output logic [NUM_FLOORS-1:0] carLamp
);

    localparam int TW = $clog2(TICK_DIV + 1);

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [HALL_W-1:0]     hall_level;
    logic [HALL_W-1:0]     hall_rise;
    logic [CAR_W:1]        car_level;
    logic [CAR_W:1]        car_rise;
    logic [HALL_W-1:0]     hall_event;
    logic [NUM_FLOORS:1]   car_event;
    logic [HALL_W-1:0]     pend_h;
    logic [NUM_FLOORS:1]   pend_c;
    logic                  spare_unused;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < HALL_W; i++) begin : g_hall
        button_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .raw    (rawHall[i]),
            .stable (hall_level[i]),
            .rise   (hall_rise[i])
        );
    end

    for (genvar i = 1; i <= CAR_W; i++) begin : g_car
        button_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .raw    (rawCar[i]),
            .stable (car_level[i]),
            .rise   (car_rise[i])
        );
    end

    assign hall_event = hall_rise & HALL_VALID_MASK;
    assign car_event  = car_rise[NUM_FLOORS:1];

    // A fresh press wins over the elevator's clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_h <= '0;
            pend_c <= '0;
        end else begin
            pend_h <= ((pend_h & nextFloorButton) | hall_event) & HALL_VALID_MASK;
            pend_c <= (pend_c & nextInternalButton[NUM_FLOORS:1]) | car_event;
        end
    end

    assign floorButton    = pend_h | hall_event;
    assign internalButton = {car_level[DOOR_CLOSE_BIT], car_level[DOOR_OPEN_BIT], pend_c | car_event};
    assign hallLamp       = pend_h;
    assign carLamp        = pend_c;

    // Door buttons are plain levels, and hall levels are only consumed through their press pulses.
    assign spare_unused = ^{hall_level, car_level[NUM_FLOORS:1], car_rise[CAR_W:NUM_FLOORS+1],
                            nextInternalButton[CAR_W:NUM_FLOORS+1]};

endmodule

// File: tb/tb_call_panel.sv
// tb/tb_call_panel.sv - directed vectors, corner sequences and random stimulus against a reference model
module tb_call_panel;

    localparam int TD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] rawHall;
    logic [9:1]  rawCar;
    logic [13:0] nextFloorButton;
    logic [9:1]  nextInternalButton;
    logic [13:0] floorButton;
    logic [9:1]  internalButton;
    logic [13:0] hallLamp;
    logic [6:0]  carLamp;

    int checks = 0;
    int errors = 0;

    call_panel #(.TICK_DIV(TD), .DB_COUNT(DB)) dut (
        .clk                (clk),
        .reset              (reset),
        .rawHall            (rawHall),
        .rawCar             (rawCar),
        .nextFloorButton    (nextFloorButton),
        .nextInternalButton (nextInternalButton),
        .floorButton        (floorButton),
        .internalButton     (internalButton),
        .hallLamp           (hallLamp),
        .carLamp            (carLamp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [43:0] act, input logic [43:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int k, input int lo, input int hi);
        checks++;
        if (k < lo || k > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", nm, k, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: bit b<14 is hall bit b, bit 13+i is car button i.
    logic [13:0] hall_ok = 14'h1FFE;
    logic [22:0] m_st;
    int          m_run [23];
    logic [13:0] m_ph;
    logic [6:0]  m_pc;
    int          m_cyc;
    bit          m_valid = 1'b0;

    always @(negedge clk) begin : model
        logic [22:0] raw_v;
        logic [22:0] rise_v;
        logic [13:0] hall_ev;
        logic [6:0]  car_ev;
        logic        tk;
        raw_v   = {rawCar, rawHall};
        rise_v  = '0;
        hall_ev = '0;
        car_ev  = '0;
        tk      = 1'b0;
        if (m_valid) begin
            tk = (m_cyc % TD) == TD - 1;
            for (int b = 0; b < 23; b++)
                rise_v[b] = tk && raw_v[b] && !m_st[b] && (m_run[b] + 1 == DB);
            hall_ev = rise_v[13:0] & hall_ok;
            car_ev  = rise_v[20:14];
            chk("model", {floorButton, internalButton, hallLamp, carLamp},
                {m_ph | hall_ev, m_st[22], m_st[21], m_pc | car_ev, m_ph, m_pc});
        end
        if (reset) begin
            m_st = '0;
            m_ph = '0;
            m_pc = '0;
            m_cyc = 0;
            for (int b = 0; b < 23; b++) m_run[b] = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_ph = ((m_ph & nextFloorButton) | hall_ev) & hall_ok;
            m_pc = (m_pc & nextInternalButton[7:1]) | car_ev;
            if (tk) begin
                for (int b = 0; b < 23; b++) begin
                    if (raw_v[b] != m_st[b]) begin
                        m_run[b]++;
                        if (m_run[b] == DB) begin
                            m_st[b] = ~m_st[b];
                            m_run[b] = 0;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end
            end
            m_cyc++;
        end
    end

    typedef struct {
        string       name;
        int          n;
        logic        rst;
        logic [13:0] hall;
        logic [9:1]  car;
        logic [13:0] nf;
        logic [13:0] fb;
        logic [9:1]  ib;
        logic [13:0] hl;
        logic [6:0]  cl;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int k;
        vecs[0]  = '{"reset",      1, 1'b1, 14'h0000, 9'h000, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[1]  = '{"hall_pre",  10, 1'b0, 14'h0004, 9'h000, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[2]  = '{"hall_evt",   1, 1'b0, 14'h0004, 9'h000, 14'h3FFF, 14'h0004, 9'h000, 14'h0000, 7'h00};
        vecs[3]  = '{"hall_lamp",  1, 1'b0, 14'h0004, 9'h000, 14'h3FFF, 14'h0004, 9'h000, 14'h0004, 7'h00};
        vecs[4]  = '{"hall_clr",   1, 1'b0, 14'h0004, 9'h000, 14'h0000, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[5]  = '{"hall_rel",  20, 1'b0, 14'h0000, 9'h000, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[6]  = '{"glitch_on",  8, 1'b0, 14'h0000, 9'h004, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[7]  = '{"glitch_off",20, 1'b0, 14'h0000, 9'h000, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[8]  = '{"invalid",   40, 1'b0, 14'h2001, 9'h000, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[9]  = '{"inv_rel",   20, 1'b0, 14'h0000, 9'h000, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};
        vecs[10] = '{"door_hold", 40, 1'b0, 14'h0000, 9'h080, 14'h3FFF, 14'h0000, 9'h080, 14'h0000, 7'h00};
        vecs[11] = '{"door_rel",  40, 1'b0, 14'h0000, 9'h000, 14'h3FFF, 14'h0000, 9'h000, 14'h0000, 7'h00};

        reset = 1'b1;
        rawHall = '0;
        rawCar = '0;
        nextFloorButton = 14'h3FFF;
        nextInternalButton = 9'h1FF;
        step();
        step();

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            rawHall = vecs[i].hall;
            rawCar = vecs[i].car;
            nextFloorButton = vecs[i].nf;
            repeat (vecs[i].n) step();
            chk(vecs[i].name, {floorButton, internalButton, hallLamp, carLamp},
                {vecs[i].fb, vecs[i].ib, vecs[i].hl, vecs[i].cl});
        end

        // Door-open level: appears on the third sampling tick, drops three ticks after release.
        rawCar = 9'h080;
        k = 0;
        while (internalButton[8] !== 1'b1 && k < 20) begin step(); k++; end
        chk_range("door_rise_lat", k, 9, 12);
        repeat (28) step();
        chk("door_no_lamp", {37'd0, carLamp}, 44'd0);
        rawCar = 9'h000;
        k = 0;
        while (internalButton[8] !== 1'b0 && k < 20) begin step(); k++; end
        chk_range("door_fall_lat", k, 9, 12);

        // Press arriving while the elevator holds the clear low still latches for one cycle.
        nextFloorButton = 14'h0000;
        rawHall = 14'h1000;
        k = 0;
        while (floorButton[12] !== 1'b1 && k < 20) begin step(); k++; end
        chk_range("setdom_lat", k, 8, 11);
        chk("setdom_evt", {floorButton, hallLamp, 16'd0}, {14'h1000, 14'h0000, 16'd0});
        step();
        chk("setdom_held", {floorButton, hallLamp, 16'd0}, {14'h1000, 14'h1000, 16'd0});
        step();
        chk("setdom_clr", {floorButton, hallLamp, 16'd0}, 44'd0);
        rawHall = 14'h0000;
        nextFloorButton = 14'h3FFF;
        repeat (20) step();

        // Reset with two pending hall calls and a car press half debounced.
        rawHall = 14'h0110;
        repeat (40) step();
        chk("two_pending", {30'd0, hallLamp}, {30'd0, 14'h0110});
        rawCar = 9'h010;
        repeat (6) step();
        reset = 1'b1;
        step();
        chk("mid_reset", {floorButton, internalButton, hallLamp, carLamp}, 44'd0);
        reset = 1'b0;
        repeat (10) step();
        chk("rearm_early", {floorButton, internalButton, hallLamp, carLamp}, 44'd0);
        step();
        chk("rearm_evt", {floorButton, internalButton, hallLamp, carLamp},
            {14'h0110, 9'h010, 14'h0000, 7'h00});
        step();
        chk("rearm_lamp", {floorButton, internalButton, hallLamp, carLamp},
            {14'h0110, 9'h010, 14'h0110, 7'h10});

        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 14; b++)
                if ($urandom_range(63) == 0) rawHall[b] = ~rawHall[b];
            for (int b = 1; b <= 9; b++)
                if ($urandom_range(63) == 0) rawCar[b] = ~rawCar[b];
            for (int b = 0; b < 14; b++) nextFloorButton[b] = ($urandom_range(7) != 0);
            for (int b = 1; b <= 9; b++) nextInternalButton[b] = ($urandom_range(7) != 0);
            reset = ($urandom_range(499) == 0);
            step();
        end
        reset = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/call_panel.md
CALL_PANEL -- requirements
Module: call_panel

Interface
REQ-001 Parameter TICK_DIV, default 10: clk cycles per debounce sample tick (>=1).
REQ-002 Parameter DB_COUNT, default 10: consecutive agreeing ticks required to change a debounced level (>=1).
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port rawHall  input  14  raw hall pushbuttons; floor f (0..6): bit 2f = down, bit 2f+1 = up.
REQ-006 Port rawCar  input  9  raw car pushbuttons, [9:1]; bits 7..1 = floors 7..1, bit 8 = door-open, bit 9 = door-close.
REQ-007 Port nextFloorButton  input  14  elevator feedback: hall requests still pending after service.
REQ-008 Port nextInternalButton  input  9  elevator feedback, [9:1]: car requests still pending after service.
REQ-009 Port floorButton  output  14  hall request vector to the elevator.
REQ-010 Port internalButton  output  9  car request vector to the elevator, [9:1].
REQ-011 Port hallLamp  output  14  hall call lamps.
REQ-012 Port carLamp  output  7  car floor lamps, bits 6..0 = floors 7..1.

Function
REQ-013 Tick: free-running counter 0..TICK_DIV-1; tick asserted for one cycle when the counter equals TICK_DIV-1.
REQ-014 Debounce, per raw bit: on each tick, if raw != stable, increment the agree counter, else clear it; when the counter reaches DB_COUNT, toggle stable and clear the counter.
REQ-015 Press event: one-cycle pulse on a stable 0->1 transition, in the same cycle stable is updated; a 1->0 transition generates no event.
REQ-016 Invalid hall bits 0 (floor 1 down) and 13 (floor 7 up) are forced to 0 in events, pending state, floorButton and hallLamp.
REQ-017 Pending hall register: pendH <= (pendH & nextFloorButton) | hallEvent; set dominates, so a press coinciding with a clear leaves the bit set.
REQ-018 Pending car floor register, bits 7..1: same rule, using nextInternalButton[7:1].
REQ-019 floorButton = pendH | hallEvent (combinational), so a request is visible to the elevator in the event cycle.
REQ-020 internalButton[7:1] = pendC | carEvent[7:1].
REQ-021 internalButton[9:8] = debounced stable levels of door-close and door-open: level while held, never latched, feedback ignored.
REQ-022 hallLamp = pendH; carLamp = pendC (registered, one cycle after the event).
REQ-023 A raw glitch shorter than DB_COUNT ticks produces no event.
REQ-024 A held button produces exactly one event; re-press requires a debounced release first.

Reset
REQ-025 While reset: tick counter, all agree counters, stable levels, pendH and pendC are 0; floorButton, internalButton, hallLamp and carLamp read 0 in the first cycle after reset is sampled.
REQ-026 A button held through reset deasserts, then registers as a new press after DB_COUNT ticks.
REQ-027 Reset mid-debounce discards partial counts.

Structure
REQ-028 Shared package holds NUM_FLOORS=7, HALL_W=14, CAR_W=9, the invalid-hall mask, and the door-open/close bit indices.
REQ-029 A single sub-module, button_debounce (one bit: tick, raw in, stable out, rise pulse out), is instantiated 23 times.

Verification (TICK_DIV=4, DB_COUNT=3)
REQ-030 rawHall=14'h0004 held from reset release -> floorButton=14'h0004 in the cycle of the 3rd tick, hallLamp=14'h0004 one cycle later.
REQ-031 rawCar bit 3 pulsed high for 8 clks (2 ticks) -> no event; internalButton stays 0.
REQ-032 pendH=14'h1000 and nextFloorButton=14'h0000 with no press -> floorButton=0 and hallLamp=0 the next cycle; if the press event coincides with the clear -> bit 12 stays set.
REQ-033 rawHall=14'h2001 held -> floorButton stays 0; invalid bits are never set.
REQ-034 rawCar bit 8 held 40 clks, then released -> internalButton[8] rises after 3 ticks, falls 3 ticks after release, and never appears in carLamp.
REQ-035 Reset pulsed while two requests are pending and one debounce is in progress -> all outputs 0 the next cycle; a still-held button re-registers after 3 ticks.
